// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result unit.
package hilo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int SRC_DIV      = 0;
  localparam int SRC_MULT     = 1;
  localparam int HILO_WIDTH   = 32;
  localparam int HILO_TIMEOUT = 64;

endpackage

// File: rtl/hilo_watchdog.sv
// Cycle counter for a pending operation; tc_o flags the last allowed WAIT cycle.
module hilo_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/hilo_unit.sv
// Registered HI/LO pair fed by NSRC multi-cycle sources, with MTHI/MTLO writes,
// read stall while a result is pending, and a watchdog abort.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH   = HILO_WIDTH,
  parameter int NSRC    = 2,
  parameter int SRCW    = $clog2(NSRC),
  parameter int TIMEOUT = HILO_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SRCW-1:0]       start_src,
  input  logic [NSRC-1:0]       src_done,
  input  logic [NSRC*WIDTH-1:0] src_hi,
  input  logic [NSRC*WIDTH-1:0] src_lo,
  input  logic                  mthi_we,
  input  logic                  mtlo_we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  rd_req,
  output logic [WIDTH-1:0]      hi_q,
  output logic [WIDTH-1:0]      lo_q,
  output logic                  busy,
  output logic                  stall,
  output logic                  res_valid,
  output logic                  err_overlap,
  output logic                  err_timeout
);

  localparam logic [SRCW:0] NSRC_L = (SRCW + 1)'(NSRC);

  state_e            state_q, state_d;
  logic [SRCW-1:0]   cur_src_q, cur_src_d;
  logic [WIDTH-1:0]  hi_reg_q, hi_d;
  logic [WIDTH-1:0]  lo_reg_q, lo_d;
  logic              res_valid_q, res_valid_d;
  logic              err_overlap_q, err_overlap_d;
  logic              err_timeout_q, err_timeout_d;

  logic [WIDTH-1:0]  sel_hi, sel_lo;
  logic              sel_done;
  logic              wd_clr, wd_en, wd_tc;

  // result slice and done bit of the source currently in flight
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    sel_done = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (cur_src_q == SRCW'(i)) begin
        sel_hi   = src_hi[i*WIDTH +: WIDTH];
        sel_lo   = src_lo[i*WIDTH +: WIDTH];
        sel_done = src_done[i];
      end else begin
        sel_hi   = sel_hi;
        sel_lo   = sel_lo;
        sel_done = sel_done;
      end
    end
  end

  // next-state: MTHI/MTLO first so a captured source result overrides them
  always_comb begin
    state_d       = state_q;
    cur_src_d     = cur_src_q;
    hi_d          = mthi_we ? wdata : hi_reg_q;
    lo_d          = mtlo_we ? wdata : lo_reg_q;
    res_valid_d   = 1'b0;
    err_overlap_d = 1'b0;
    err_timeout_d = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, start_src} < NSRC_L) begin
            cur_src_d = start_src;
            wd_clr    = 1'b1;
            state_d   = WAIT;
          end else begin
            err_overlap_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        err_overlap_d = start;
        if (sel_done) begin
          hi_d        = sel_hi;
          lo_d        = sel_lo;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wd_tc) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wd_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, HI/LO and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_src_q     <= '0;
      hi_reg_q      <= '0;
      lo_reg_q      <= '0;
      res_valid_q   <= 1'b0;
      err_overlap_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_src_q     <= cur_src_d;
      hi_reg_q      <= hi_d;
      lo_reg_q      <= lo_d;
      res_valid_q   <= res_valid_d;
      err_overlap_q <= err_overlap_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  hilo_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  assign hi_q        = hi_reg_q;
  assign lo_q        = lo_reg_q;
  assign busy        = (state_q == WAIT);
  assign stall       = rd_req & busy;
  assign res_valid   = res_valid_q;
  assign err_overlap = err_overlap_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus a random run
// against a transaction-level model of the HI/LO unit.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int W  = 32;
  localparam int NS = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [0:0]      start_src = 1'b0;
  logic [NS-1:0]   src_done = '0;
  logic [NS*W-1:0] src_hi = '0;
  logic [NS*W-1:0] src_lo = '0;
  logic            mthi_we = 1'b0;
  logic            mtlo_we = 1'b0;
  logic [W-1:0]    wdata = '0;
  logic            rd_req = 1'b0;
  logic [W-1:0]    hi_q, lo_q;
  logic            busy, stall, res_valid, err_overlap, err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: architectural HI/LO, pending flag, source and edges waited
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit m_busy = 1'b0;
  int m_src  = 0;
  int m_age  = 0;
  bit m_rv = 1'b0, m_ov = 1'b0, m_to = 1'b0;

  hilo_unit #(.WIDTH(W), .NSRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_src(start_src),
    .src_done(src_done), .src_hi(src_hi), .src_lo(src_lo),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata), .rd_req(rd_req),
    .hi_q(hi_q), .lo_q(lo_q), .busy(busy), .stall(stall),
    .res_valid(res_valid), .err_overlap(err_overlap), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // one clock edge: update the model with the inputs seen at the edge, then clear one-shot inputs
  task automatic cycle();
    logic [W-1:0] nh, nl;
    @(posedge clk);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_age = 0;
      m_rv = 1'b0; m_ov = 1'b0; m_to = 1'b0;
    end else begin
      m_rv = 1'b0; m_ov = 1'b0; m_to = 1'b0;
      nh = mthi_we ? wdata : m_hi;
      nl = mtlo_we ? wdata : m_lo;
      if (!m_busy) begin
        if (start) begin
          if (int'(start_src) < NS) begin
            m_busy = 1'b1; m_src = int'(start_src); m_age = 0;
          end else m_ov = 1'b1;
        end
      end else begin
        if (start) m_ov = 1'b1;
        if (src_done[m_src]) begin
          nh = src_hi[m_src*W +: W];
          nl = src_lo[m_src*W +: W];
          m_rv = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_age++;
          if (m_age == TO) begin
            m_to = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
      m_hi = nh; m_lo = nl;
    end
    #1;
    start = 1'b0; src_done = '0; mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_req = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    n_cmp++; if (hi_q !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_q); end
    n_cmp++; if (lo_q !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_q); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if ({res_valid, err_overlap, err_timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {res_valid, err_overlap, err_timeout});
    end
    rd_req = 1'b0;
  endtask

  task automatic test_mult();
    int stalls = 0;
    rd_req = 1'b1;
    start = 1'b1; start_src = 1'(SRC_MULT);
    cycle(); if (stall) stalls++;
    repeat (5) begin cycle(); if (stall) stalls++; end
    src_done = 2'b10;
    src_hi[W +: W] = 32'h0000_0001; src_lo[W +: W] = 32'hFFFF_FFFE;
    src_hi[0 +: W] = $urandom;      src_lo[0 +: W] = $urandom;
    cycle(); if (stall) stalls++;
    n_cmp++; if (hi_q !== 32'h0000_0001) begin n_fail++; $display("FAIL mult_hi: got %h want 00000001", hi_q); end
    n_cmp++; if (lo_q !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffe", lo_q); end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL mult_valid: got %b want 1", res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy: got %b want 0", busy); end
    n_cmp++; if (stalls != 6) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d want 6", stalls); end
    cycle();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mult_valid_once: got %b want 0", res_valid); end
    rd_req = 1'b0;
  endtask

  task automatic test_wrong_src();
    start = 1'b1; start_src = 1'(SRC_DIV);
    cycle();
    src_done = 2'b10; src_hi[W +: W] = $urandom; src_lo[W +: W] = $urandom;
    cycle();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wrong_src_valid: got %b want 0", res_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrong_src_busy: got %b want 1", busy); end
    n_cmp++; if (hi_q !== 32'h0000_0001) begin n_fail++; $display("FAIL wrong_src_hi: got %h want 00000001", hi_q); end
    src_done = 2'b01; src_hi[0 +: W] = 32'd7; src_lo[0 +: W] = 32'd3;
    cycle();
    n_cmp++; if (hi_q !== 32'd7) begin n_fail++; $display("FAIL div_hi: got %h want 7", hi_q); end
    n_cmp++; if (lo_q !== 32'd3) begin n_fail++; $display("FAIL div_lo: got %h want 3", lo_q); end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL div_valid: got %b want 1", res_valid); end
  endtask

  task automatic test_overlap();
    logic [W-1:0] r_hi, r_lo;
    r_hi = $urandom; r_lo = $urandom;
    start = 1'b1; start_src = 1'(SRC_MULT);
    cycle();
    start = 1'b1; start_src = 1'(SRC_DIV);
    cycle();
    n_cmp++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL overlap_pulse: got %b want 1", err_overlap); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL overlap_busy: got %b want 1", busy); end
    start = 1'b1; start_src = 1'(SRC_DIV);
    src_done = 2'b10; src_hi[W +: W] = r_hi; src_lo[W +: W] = r_lo;
    cycle();
    n_cmp++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL overlap_done_pulse: got %b want 1", err_overlap); end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL overlap_done_valid: got %b want 1", res_valid); end
    n_cmp++; if (hi_q !== r_hi || lo_q !== r_lo) begin
      n_fail++; $display("FAIL overlap_capture: got %h/%h want %h/%h", hi_q, lo_q, r_hi, r_lo);
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overlap_busy_after: got %b want 0", busy); end
    cycle();
    n_cmp++; if (err_overlap !== 1'b0) begin n_fail++; $display("FAIL overlap_once: got %b want 0", err_overlap); end
  endtask

  task automatic test_timeout();
    int edges = 0;
    logic [W-1:0] h0, l0;
    h0 = m_hi; l0 = m_lo;
    start = 1'b1; start_src = 1'(SRC_DIV);
    cycle();
    while (err_timeout !== 1'b1 && edges < 3*TO) begin cycle(); edges++; end
    n_cmp++; if (edges != TO) begin n_fail++; $display("FAIL timeout_edges: got %0d want %0d", edges, TO); end
    n_cmp++; if (hi_q !== h0 || lo_q !== l0) begin
      n_fail++; $display("FAIL timeout_hilo: got %h/%h want %h/%h", hi_q, lo_q, h0, l0);
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    start = 1'b1; start_src = 1'(SRC_MULT);
    cycle();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_restart: got %b want 1", busy); end
    src_done = 2'b10; src_hi[W +: W] = 32'h1111_2222; src_lo[W +: W] = 32'h3333_4444;
    cycle();
    n_cmp++; if (hi_q !== 32'h1111_2222) begin n_fail++; $display("FAIL timeout_next_hi: got %h want 11112222", hi_q); end
  endtask

  task automatic test_mt();
    logic [W-1:0] s_hi, s_lo, w;
    mthi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    cycle();
    mtlo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    cycle();
    n_cmp++; if (hi_q !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi: got %h want a5a5a5a5", hi_q); end
    n_cmp++; if (lo_q !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL mtlo: got %h want 5a5a5a5a", lo_q); end
    w = $urandom;
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = w;
    cycle();
    n_cmp++; if (hi_q !== w || lo_q !== w) begin n_fail++; $display("FAIL mt_both: got %h/%h want %h", hi_q, lo_q, w); end
    start = 1'b1; start_src = 1'(SRC_DIV);
    cycle();
    mthi_we = 1'b1; wdata = 32'h0000_1234;
    cycle();
    n_cmp++; if (hi_q !== 32'h0000_1234 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mt_in_wait: got %h busy %b want 00001234 busy 1", hi_q, busy);
    end
    s_hi = $urandom; s_lo = $urandom;
    src_done = 2'b01; src_hi[0 +: W] = s_hi; src_lo[0 +: W] = s_lo;
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    cycle();
    n_cmp++; if (hi_q !== s_hi || lo_q !== s_lo) begin
      n_fail++; $display("FAIL mt_src_wins: got %h/%h want %h/%h", hi_q, lo_q, s_hi, s_lo);
    end
  endtask

  task automatic test_reset_midwait();
    int tos = 0;
    start = 1'b1; start_src = 1'(SRC_MULT);
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
      n_fail++; $display("FAIL reset_midwait: got busy %b hi %h lo %h want 0/0/0", busy, hi_q, lo_q);
    end
    repeat (TO + 2) begin cycle(); if (err_timeout) tos++; end
    n_cmp++; if (tos != 0) begin n_fail++; $display("FAIL reset_midwait_silent: got %0d timeouts want 0", tos); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      start     = ($urandom_range(3) == 0);
      start_src = 1'($urandom_range(1));
      src_done  = ($urandom_range(5) == 0) ? NS'($urandom_range(3)) : '0;
      src_hi    = {$urandom, $urandom};
      src_lo    = {$urandom, $urandom};
      mthi_we   = ($urandom_range(7) == 0);
      mtlo_we   = ($urandom_range(7) == 0);
      wdata     = $urandom;
      cycle();
      rd_req = 1'($urandom_range(1));
      #1;
      n_cmp++; if (hi_q !== m_hi) begin n_fail++; $display("FAIL rnd_hi @%0d: got %h want %h", k, hi_q, m_hi); end
      n_cmp++; if (lo_q !== m_lo) begin n_fail++; $display("FAIL rnd_lo @%0d: got %h want %h", k, lo_q, m_lo); end
      n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", k, busy, m_busy); end
      n_cmp++; if (stall !== (rd_req & m_busy)) begin
        n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", k, stall, rd_req & m_busy);
      end
      n_cmp++; if ({res_valid, err_overlap, err_timeout} !== {m_rv, m_ov, m_to}) begin
        n_fail++; $display("FAIL rnd_pulses @%0d: got %b want %b", k, {res_valid, err_overlap, err_timeout}, {m_rv, m_ov, m_to});
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_wrong_src();
    test_overlap();
    test_timeout();
    test_mt();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
